y_unload_buffer: RTL and testbench
==================================

Y_UNLOAD_BUFFER -- requirements
Module: y_unload_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, result slots per lane (power of 2, range 2..16).
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have cap_valid  input  1  four lane results present this cycle.
REQ-005 SHALL have y_in1, y_in2, y_in3, y_in4  input  18 each  signed lane accumulator results.
REQ-006 SHALL have flush  input  1  request early unload of a partially filled buffer.
REQ-007 SHALL have cap_ready  output  1  buffer accepts a capture this cycle.
REQ-008 SHALL have out_valid  output  1  out_data holds a valid byte.
REQ-009 SHALL have out_ready  input  1  downstream accepts the byte.
REQ-010 SHALL have out_data  output  8  serialized result byte.
REQ-011 SHALL have unload_done  output  1  single-cycle pulse when the last byte is accepted.
REQ-012 SHALL have ovf  output  1  sticky flag: capture attempted while not ready.

Function
REQ-013 SHALL implement two states, FILL and DRAIN; cap_ready = (state==FILL); out_valid = (state==DRAIN).
REQ-014 In FILL, cap_valid&&cap_ready SHALL store the four 16-bit converted results into slot wr_cnt of lanes 1..4 and increment wr_cnt.
REQ-015 Capture making wr_cnt==DEPTH SHALL transition to DRAIN next cycle with n_slots=DEPTH.
REQ-016 flush in FILL with wr_cnt>0 SHALL transition to DRAIN with n_slots=wr_cnt; a capture in the same cycle is accepted first and included.
REQ-017 flush in FILL with wr_cnt==0 and no capture SHALL be ignored; flush in DRAIN SHALL be ignored.
REQ-018 Byte order SHALL be slot-major, then lane 1..4, then high byte before low byte: byte k = slot k/8, lane (k/2)%4+1, high if k even.
REQ-019 Byte pointer SHALL advance only on out_valid&&out_ready; out_data SHALL be stable while out_valid&&!out_ready.
REQ-020 out_data SHALL be 8'h00 when out_valid is 0.
REQ-021 Acceptance of byte 8*n_slots-1 SHALL pulse unload_done for one cycle and return to FILL with wr_cnt=0 and byte pointer=0 on the same edge.
REQ-022 cap_valid in DRAIN SHALL be dropped (no storage change) and set ovf=1; ovf is cleared only by reset.
REQ-023 Latency: first byte valid one cycle after the capture or flush that triggers DRAIN.

Reset
REQ-024 Reset assertion SHALL immediately force state=FILL, wr_cnt=0, byte pointer=0, storage=0, out_valid=0, out_data=0, unload_done=0, ovf=0, cap_ready=1, including mid-DRAIN.

Configuration
REQ-025 Macro Y_SAT_EN defined: each 18-bit input SHALL be saturated to signed 16-bit (>32767 -> 16'h7FFF, <-32768 -> 16'h8000).
REQ-026 Macro Y_SAT_EN undefined: each input SHALL be truncated to bits [15:0].

Verification
REQ-027 DEPTH=8, 8 captures with y_inL=0x1000*L+slot, out_ready=1 -> 64 bytes 10 00 20 00 30 00 40 00 10 01 ...; unload_done on byte 64; cap_ready returns to 1.
REQ-028 out_ready low 3 cycles while byte 5 is presented -> out_data held at 0x30 (slot0 lane3 high) with out_valid=1; stream resumes without loss.
REQ-029 3 captures then flush -> exactly 24 bytes; unload_done on byte 24; wr_cnt=0 afterward.
REQ-030 cap_valid during DRAIN -> stored bytes unchanged, ovf=1 and remains 1 through the next FILL.
REQ-031 Input 18'h1FFFF and 18'h20000: Y_SAT_EN -> 16'h7FFF, 16'h8000; undefined -> 16'hFFFF, 16'h0000.
REQ-032 rst asserted at byte 10 of DRAIN -> out_valid=0 and cap_ready=1 immediately; next 8 captures unload from byte 0.

Source files
------------

// File: rtl/y_unload_buffer.sv
// Result unload buffer: captures four lane results per cycle into DEPTH slots and
// serializes them as a byte stream. Define Y_SAT_EN to saturate inputs to 16 bits instead of truncating.
module y_unload_buffer #(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cap_valid,
    input  logic signed [17:0] y_in1,
    input  logic signed [17:0] y_in2,
    input  logic signed [17:0] y_in3,
    input  logic signed [17:0] y_in4,
    input  logic               flush,
    output logic               cap_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               unload_done,
    output logic               ovf
);

    localparam int SW = $clog2(DEPTH);
    localparam int CW = SW + 1;
    localparam int PW = SW + 3;

    typedef enum logic {FILL, DRAIN} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] wr_cnt_reg, wr_cnt_next;
    logic [CW-1:0] n_slots_reg, n_slots_next;
    logic [PW-1:0] ptr_reg, ptr_next;
    logic          ovf_reg;

    logic [3:0][17:0] lane_in;
    logic [15:0]      conv [4];
    logic [15:0]      lane_word [4];
    logic [15:0]      sel_word;
    logic [CW-1:0]    cnt_after;
    logic [CW-1:0]    last_slot;
    logic             cap_fire;
    logic             last_byte;

    assign lane_in[0] = y_in1;
    assign lane_in[1] = y_in2;
    assign lane_in[2] = y_in3;
    assign lane_in[3] = y_in4;

    assign cap_fire  = cap_valid && (state_reg == FILL);
    assign last_slot = n_slots_reg - CW'(1);
    // Byte pointer layout: {slot, lane[1:0], low_byte}
    assign last_byte = ({1'b0, ptr_reg[PW-1:3]} == last_slot) && (&ptr_reg[2:0]);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [15:0] mem_reg [DEPTH];

`ifdef Y_SAT_EN
        // In range exactly when the top three bits agree
        assign conv[gi] = (lane_in[gi][17:15] == 3'b000 || lane_in[gi][17:15] == 3'b111)
                        ? lane_in[gi][15:0]
                        : (lane_in[gi][17] ? 16'h8000 : 16'h7FFF);
`else
        logic [1:0] unused_hi;
        assign unused_hi = lane_in[gi][17:16];
        assign conv[gi]  = lane_in[gi][15:0];
`endif

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_reg[i] <= '0;
                end
            end else if (cap_fire) begin
                mem_reg[wr_cnt_reg[SW-1:0]] <= conv[gi];
            end
        end

        assign lane_word[gi] = mem_reg[ptr_reg[PW-1:3]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= FILL;
            wr_cnt_reg  <= '0;
            n_slots_reg <= '0;
            ptr_reg     <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wr_cnt_reg  <= wr_cnt_next;
            n_slots_reg <= n_slots_next;
            ptr_reg     <= ptr_next;
            if (cap_valid && (state_reg == DRAIN)) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        wr_cnt_next  = wr_cnt_reg;
        n_slots_next = n_slots_reg;
        ptr_next     = ptr_reg;
        cnt_after    = wr_cnt_reg + CW'(cap_fire);
        case (state_reg)
            FILL: begin
                wr_cnt_next = cnt_after;
                // A same-cycle capture is counted before deciding on flush
                if ((cnt_after == CW'(DEPTH)) || (flush && (cnt_after != '0))) begin
                    state_next   = DRAIN;
                    n_slots_next = cnt_after;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (last_byte) begin
                        state_next  = FILL;
                        wr_cnt_next = '0;
                        ptr_next    = '0;
                    end else begin
                        ptr_next = ptr_reg + PW'(1);
                    end
                end
            end
            default: state_next = FILL;
        endcase
    end

    assign sel_word    = lane_word[ptr_reg[2:1]];
    assign cap_ready   = (state_reg == FILL);
    assign out_valid   = (state_reg == DRAIN);
    assign out_data    = out_valid ? (ptr_reg[0] ? sel_word[7:0] : sel_word[15:8]) : 8'h00;
    assign unload_done = out_valid && out_ready && last_byte;
    assign ovf         = ovf_reg;

endmodule

// File: tb/tb_y_unload_buffer.sv
// Self-checking bench for y_unload_buffer: random captures are checked against a
// byte-queue reference model built directly from the capture data.
module tb_y_unload_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cap_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [17:0] y_in1 = '0, y_in2 = '0, y_in3 = '0, y_in4 = '0;
    logic        cap_ready, out_valid, unload_done, ovf;
    logic [7:0]  out_data;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    y_unload_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cap_valid(cap_valid),
        .y_in1(y_in1), .y_in2(y_in2), .y_in3(y_in3), .y_in4(y_in4),
        .flush(flush), .cap_ready(cap_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
        .unload_done(unload_done), .ovf(ovf)
    );

    // Reference conversion from the numeric value of the signed 18-bit input
    function automatic logic [15:0] conv(input logic [17:0] y);
`ifdef Y_SAT_EN
        int v;
        v = int'($signed(y));
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        return y[15:0];
    endfunction

    // Drives one capture and appends its eight bytes (lane 1..4, high then low) to the model
    task automatic capture(input logic [17:0] a, b, c, d, input logic fl);
        logic [15:0] w [4];
        @(negedge clk);
        cap_valid = 1'b1; flush = fl;
        y_in1 = a; y_in2 = b; y_in3 = c; y_in4 = d;
        w[0] = conv(a); w[1] = conv(b); w[2] = conv(c); w[3] = conv(d);
        for (int l = 0; l < 4; l++) begin
            exp_q.push_back(w[l][15:8]);
            exp_q.push_back(w[l][7:0]);
        end
        $display("capture: %h %h %h %h flush=%b", a, b, c, d, fl);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({cap_ready, out_valid, out_data, unload_done, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b data=%h done=%b ovf=%b, required 1 0 00 0 0",
                     cap_ready, out_valid, out_data, unload_done, ovf);
        end
        @(negedge clk); rst = 1'b1;
        $display("reset released");
    endtask

    task automatic test_flush_empty();
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0; #1;
        checks++;
        if (cap_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: ready=%b valid=%b, required 1 0", cap_ready, out_valid);
        end
        $display("flush on empty buffer: ready=%b valid=%b", cap_ready, out_valid);
    endtask

    task automatic test_full_backpressure();
        int idx = 0, hold = 0, guard = 0;
        for (int s = 0; s < DEPTH; s++)
            capture(18'h01000 + 18'(s), 18'h02000 + 18'(s), 18'h03000 + 18'(s), 18'h04000 + 18'(s), 1'b0);
        while (exp_q.size() > 0 && guard < 1000) begin
            @(negedge clk); cap_valid = 1'b0; flush = 1'b0;
            out_ready = !(idx == 4 && hold < 3);
            #1; guard++;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                errors++;
                $display("FAIL full_byte %0d: valid=%b data=%h, required valid=1 data=%h", idx, out_valid, out_data, exp_q[0]);
            end
            if (idx == 4 && !out_ready) begin
                hold++;
                checks++;
                if (out_data !== 8'h30) begin
                    errors++;
                    $display("FAIL held_byte: data=%h, required 30", out_data);
                end
            end
            checks++;
            if (unload_done !== (out_ready && exp_q.size() == 1)) begin
                errors++;
                $display("FAIL full_done %0d: done=%b, required %b", idx, unload_done, out_ready && exp_q.size() == 1);
            end
            $display("byte %0d: data=%h ready=%b done=%b", idx, out_data, out_ready, unload_done);
            if (out_ready) begin void'(exp_q.pop_front()); idx++; end
        end
        @(negedge clk); #1;
        checks++;
        if (cap_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || idx != 8 * DEPTH) begin
            errors++;
            $display("FAIL full_end: ready=%b valid=%b data=%h bytes=%0d, required 1 0 00 %0d",
                     cap_ready, out_valid, out_data, idx, 8 * DEPTH);
        end
    endtask

    task automatic test_flush_partial();
        int idx = 0, guard = 0;
        for (int s = 0; s < 3; s++)
            capture(18'($urandom()), 18'($urandom()), 18'($urandom()), 18'($urandom()), 1'b0);
        @(negedge clk); cap_valid = 1'b0; flush = 1'b1;
        while (exp_q.size() > 0 && guard < 1000) begin
            @(negedge clk); cap_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
            #1; guard++;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0] || unload_done !== (exp_q.size() == 1)) begin
                errors++;
                $display("FAIL flush_byte %0d: valid=%b data=%h done=%b, required 1 %h %b",
                         idx, out_valid, out_data, unload_done, exp_q[0], exp_q.size() == 1);
            end
            $display("flush byte %0d: data=%h done=%b", idx, out_data, unload_done);
            void'(exp_q.pop_front()); idx++;
        end
        // Buffer must be empty again: a flush alone must not start another unload
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0; #1;
        checks++;
        if (idx != 24 || cap_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_end: bytes=%0d ready=%b valid=%b, required 24 1 0", idx, cap_ready, out_valid);
        end
    endtask

    task automatic test_saturation();
        int idx = 0, guard = 0;
        capture(18'h1FFFF, 18'h20000, 18'h07FFF, 18'h38000, 1'b1);
        while (exp_q.size() > 0 && guard < 100) begin
            @(negedge clk); cap_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
            #1; guard++;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                errors++;
                $display("FAIL sat_byte %0d: valid=%b data=%h, required 1 %h", idx, out_valid, out_data, exp_q[0]);
            end
            $display("sat byte %0d: data=%h", idx, out_data);
            void'(exp_q.pop_front()); idx++;
        end
    endtask

    task automatic test_ovf();
        int idx = 0, guard = 0;
        for (int s = 0; s < DEPTH; s++)
            capture(18'($urandom()), 18'($urandom()), 18'($urandom()), 18'($urandom()), 1'b0);
        @(negedge clk);
        cap_valid = 1'b1; out_ready = 1'b0;
        y_in1 = 18'h15555; y_in2 = 18'h0AAAA; y_in3 = 18'h13333; y_in4 = 18'h0CCCC;
        #1;
        checks++;
        if (out_valid !== 1'b1 || cap_ready !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pre: valid=%b ready=%b ovf=%b, required 1 0 0", out_valid, cap_ready, ovf);
        end
        while (exp_q.size() > 0 && guard < 1000) begin
            @(negedge clk); cap_valid = 1'b0; out_ready = 1'($urandom_range(0, 1));
            #1; guard++;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0] || ovf !== 1'b1) begin
                errors++;
                $display("FAIL ovf_byte %0d: valid=%b data=%h ovf=%b, required 1 %h 1", idx, out_valid, out_data, ovf, exp_q[0]);
            end
            if (out_ready) begin void'(exp_q.pop_front()); idx++; end
        end
        @(negedge clk); #1;
        checks++;
        if (ovf !== 1'b1 || cap_ready !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b ready=%b, required 1 1", ovf, cap_ready);
        end
        $display("ovf test: bytes=%0d ovf=%b", idx, ovf);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int n, idx = 0, guard = 0;
            logic same;
            n = $urandom_range(1, DEPTH);
            same = 1'($urandom_range(0, 1));
            for (int s = 0; s < n; s++)
                capture(18'($urandom()), 18'($urandom()), 18'($urandom()), 18'($urandom()),
                        (s == n - 1) && same);
            if (n < DEPTH && !same) begin
                @(negedge clk); cap_valid = 1'b0; flush = 1'b1;
            end
            while (exp_q.size() > 0 && guard < 2000) begin
                @(negedge clk); cap_valid = 1'b0;
                flush = 1'($urandom_range(0, 1));
                out_ready = ($urandom_range(0, 3) != 0);
                #1; guard++;
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_q[0] ||
                    unload_done !== (out_ready && exp_q.size() == 1)) begin
                    errors++;
                    $display("FAIL rand_byte r%0d b%0d: valid=%b data=%h done=%b, required 1 %h %b",
                             r, idx, out_valid, out_data, unload_done, exp_q[0], out_ready && exp_q.size() == 1);
                end
                if (out_ready) begin void'(exp_q.pop_front()); idx++; end
            end
            @(negedge clk); flush = 1'b0; #1;
            checks++;
            if (exp_q.size() != 0 || idx != 8 * n || cap_ready !== 1'b1) begin
                errors++;
                $display("FAIL rand_end r%0d: bytes=%0d ready=%b, required %0d 1", r, idx, cap_ready, 8 * n);
            end
            $display("random round %0d: slots=%0d bytes=%0d", r, n, idx);
        end
    endtask

    task automatic test_reset_mid_drain();
        int idx = 0, guard = 0;
        for (int s = 0; s < DEPTH; s++)
            capture(18'($urandom()), 18'($urandom()), 18'($urandom()), 18'($urandom()), 1'b0);
        for (int b = 0; b < 10; b++) begin
            @(negedge clk); cap_valid = 1'b0; out_ready = 1'b1;
        end
        @(negedge clk); out_ready = 1'b0;
        #2; rst = 1'b0; #1;
        checks++;
        if ({cap_ready, out_valid, out_data, unload_done, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: ready=%b valid=%b data=%h done=%b ovf=%b, required 1 0 00 0 0",
                     cap_ready, out_valid, out_data, unload_done, ovf);
        end
        $display("reset mid-drain: ready=%b valid=%b", cap_ready, out_valid);
        exp_q.delete();
        @(negedge clk); rst = 1'b1;
        for (int s = 0; s < DEPTH; s++)
            capture(18'($urandom()), 18'($urandom()), 18'($urandom()), 18'($urandom()), 1'b0);
        while (exp_q.size() > 0 && guard < 1000) begin
            @(negedge clk); cap_valid = 1'b0; out_ready = 1'b1;
            #1; guard++;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                errors++;
                $display("FAIL post_reset_byte %0d: valid=%b data=%h, required 1 %h", idx, out_valid, out_data, exp_q[0]);
            end
            void'(exp_q.pop_front()); idx++;
        end
        $display("post-reset unload: bytes=%0d", idx);
    endtask

    initial begin
        test_reset();
        test_flush_empty();
        test_full_backpressure();
        test_flush_partial();
        test_saturation();
        test_ovf();
        test_random();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
